credit_sender: RTL and testbench
================================

Name: credit_sender

Overview:
Transmit end of a credit-based link. Accepts words on a stream (valid/ready) interface and issues them on a flow interface, which has no ready. Never issues more words than the downstream receiver has advertised space for. The downstream receiver (typically an sfifo-backed credit receiver) returns one credit per word it frees; this block counts them.

Parameters:
T, logic[31:0], payload type carried on both the stream and the flow interfaces.
CREDITS, 32, initial and maximum credit count; equals the downstream buffer capacity in words.

Ports:
clock  input  1  clock; all logic on rising edge.
reset  input  1  reset; synchronous, active-low.
receiver  stream.receive  $bits(T)+2  upstream words in (data, valid, ready).
sender  flow.send  $bits(T)+1  words out to the link (data, valid); no backpressure.
credit_in  flow.receive  1  credit return; each cycle with credit_in.valid=1 returns exactly one credit; data is ignored.
credit_count  output  $clog2(CREDITS+1)  current credit counter value (registered).
overflow  output  1  sticky error: a credit was returned while the counter was already at CREDITS.

Behaviour:
- Reset values (reset=0 at a rising edge):
  - credit_count=CREDITS
  - sender.valid=0
  - receiver.ready=0 during the reset cycle, then 1
  - skid buffer emptied
  - overflow=0
  - sender.data is don't-care.
- Reset mid-operation discards all buffered words. Credits revert to CREDITS; the downstream side is reset in the same domain.
- Input stage: 2-entry skid buffer (head, spare).
  - receiver.ready is registered and equals "spare entry empty".
  - A word transfers when receiver.valid && receiver.ready at the edge.
  - Into head if head is empty or head is issuing this cycle; otherwise into spare.
  - Spare moves into head when head issues.
- Issue condition, evaluated each cycle: issue = head_valid && (credit_count != 0).
  - Credits returned in the same cycle are NOT usable until the next cycle (no comb path credit_in -> sender).
- Output register: at each edge sender.valid <= issue; if issue, sender.data <= head data.
  - sender.valid is high for exactly one cycle per word, in order, no duplication or loss.
- Latency: word accepted at edge E0 appears on sender after edge E1 (one cycle), given credit_count>0 and head empty or issuing at E1.
- Throughput: one word per cycle sustained while credits>0 and upstream valid.
- Credit counter: next = credit_count - issue + credit_in.valid, with width $clog2(CREDITS+1).
  - Issue and return in the same cycle: count unchanged.
  - Count 0 with a return and no issue: becomes 1; issue resumes the following cycle.
  - Return at count==CREDITS with no issue: count stays CREDITS (saturate) and overflow <= 1. overflow holds until reset.
  - Count can never underflow: issue requires count != 0.
- Backpressure: with credits at 0 and both skid entries full, receiver.ready=0 at the next edge. Upstream data is held until credits return.
- No state machine beyond the occupancy states of the skid buffer (EMPTY, ONE, TWO). Transitions are determined by {accept, issue}.
  - EMPTY -> ONE on accept.
  - ONE -> TWO on accept && !issue.
  - ONE -> EMPTY on issue && !accept.
  - TWO -> ONE on issue; accept is impossible in TWO because ready=0.

Decomposition:
- Shared package powlib_pkg: credit-counter width helper function (clog2(N+1)).
- Sub-module stream_skid: the 2-entry skid buffer with stream.receive in and stream.send out.
  - Reused by other stream blocks.
  - Here, its send.ready is driven by issue.
- credit_sender holds only the credit counter, the issue logic and the output register.

Test Plan:
- Reset release, CREDITS=4: stream 6 words 0x10..0x15 back-to-back, no credit returns.
  - Required: sender.valid for 0x10..0x13 on 4 consecutive cycles starting 1 cycle after the first accept.
  - credit_count steps 4->0.
  - receiver.ready drops after 0x15 is buffered.
- From the previous state, pulse credit_in.valid for 1 cycle.
  - Required: credit_count 0->1; 0x14 issued the following cycle; count back to 0.
- Simultaneous issue and return, with credits=2 and continuous traffic and return every cycle.
  - Required: credit_count constant at 2; one word per cycle; data order preserved.
- Overflow: at credit_count=CREDITS with no traffic, pulse credit_in.valid.
  - Required: count stays CREDITS; overflow=1 and remains 1 for 100 cycles.
- Reset mid-stream: assert reset for 1 cycle with 2 words buffered and credits=1.
  - Required: next cycle sender.valid=0, credit_count=CREDITS, overflow=0.
  - Buffered words are never emitted.
- Random upstream valid (50%) and random credit return against a CREDITS-deep scoreboard model.
  - Required: outstanding words never exceed CREDITS; the output sequence equals the input sequence.

Source files
------------

// File: rtl/credit_sender_pkg.sv
// Shared types and helpers for the credit_sender slice: skid-buffer
// occupancy encoding and the credit-counter width helper.
package credit_sender_pkg;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_t;

    // Counter must hold every value 0..n inclusive.
    function automatic int credit_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/credit_sender_if.sv
// Link interfaces. stream: a word moves when valid && ready are both high at
// a rising edge; data is meaningful only while valid. flow: same, without ready.
interface stream_if #(parameter type T = logic [31:0]) ();
    T     data;
    logic valid;
    logic ready;

    modport send    (output data, output valid, input  ready);
    modport receive (input  data, input  valid, output ready);
endinterface

interface flow_if #(parameter type T = logic [31:0]) ();
    T     data;
    logic valid;

    modport send    (output data, output valid);
    modport receive (input  data, input  valid);
endinterface

// File: rtl/credit_sender_skid.sv
// Two-entry skid buffer (head + spare) between two stream interfaces.
// ready is registered and reflects "spare entry empty" for the coming cycle.
module stream_skid
    import credit_sender_pkg::*;
#(
    parameter type T = logic [31:0]
) (
    input  logic          clock,
    input  logic          reset,
    stream_if.receive     receive,
    stream_if.send        send,
    output skid_state_t   o_state
);

    skid_state_t r_state;
    skid_state_t w_next;
    T            r_head;
    T            r_spare;
    logic        r_ready;
    logic        w_accept;
    logic        w_pop;
    logic        w_load_head_in;
    logic        w_load_head_spare;
    logic        w_load_spare;

    assign w_accept = receive.valid && r_ready;
    assign w_pop    = send.ready && (r_state != SKID_EMPTY);

    always_comb begin
        w_next            = r_state;
        w_load_head_in    = 1'b0;
        w_load_head_spare = 1'b0;
        w_load_spare      = 1'b0;
        case (r_state)
            SKID_EMPTY: begin
                if (w_accept) begin
                    w_next         = SKID_ONE;
                    w_load_head_in = 1'b1;
                end
            end
            SKID_ONE: begin
                if (w_accept && w_pop) begin
                    w_load_head_in = 1'b1;
                end else if (w_accept) begin
                    w_next       = SKID_TWO;
                    w_load_spare = 1'b1;
                end else if (w_pop) begin
                    w_next = SKID_EMPTY;
                end
            end
            SKID_TWO: begin
                // ready is low here, so only a pop can happen
                if (w_pop) begin
                    w_next            = SKID_ONE;
                    w_load_head_spare = 1'b1;
                end
            end
            default: w_next = SKID_EMPTY;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= SKID_EMPTY;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ready <= (w_next != SKID_TWO);
        end
    end

    always_ff @(posedge clock) begin
        if (w_load_head_in) begin
            r_head <= receive.data;
        end else if (w_load_head_spare) begin
            r_head <= r_spare;
        end
        if (w_load_spare) begin
            r_spare <= receive.data;
        end
    end

    assign receive.ready = r_ready;
    assign send.valid    = (r_state != SKID_EMPTY);
    assign send.data     = r_head;
    assign o_state       = r_state;

endmodule

// File: rtl/credit_sender.sv
// Transmit end of a credit-based link: buffers upstream words and issues them
// only while the downstream receiver has advertised free space.
module credit_sender
    import credit_sender_pkg::*;
#(
    parameter type T       = logic [31:0],
    parameter int  CREDITS = 32
) (
    input  logic                              clock,
    input  logic                              reset,
    stream_if.receive                         receiver,
    flow_if.send                              sender,
    flow_if.receive                           credit_in,
    output logic [credit_width(CREDITS)-1:0]  credit_count,
    output logic                              overflow
);

    localparam int            CW   = credit_width(CREDITS);
    localparam logic [CW-1:0] FULL = CW'(CREDITS);

    stream_if #(.T(T)) w_head ();

    skid_state_t   w_unused_skid_state;
    logic          w_unused_credit_data;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic          r_valid;
    T              r_data;
    logic          w_issue;
    logic          w_ret;

    stream_skid #(.T(T)) u_skid (
        .clock   (clock),
        .reset   (reset),
        .receive (receiver),
        .send    (w_head),
        .o_state (w_unused_skid_state)
    );

    // Uses only the registered count, so a credit returned this cycle waits a cycle.
    assign w_issue      = w_head.valid && (r_count != '0);
    assign w_head.ready = w_issue;
    assign w_ret        = credit_in.valid;

    assign w_unused_credit_data = ^credit_in.data;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_count    <= FULL;
            r_overflow <= 1'b0;
        end else begin
            case ({w_issue, w_ret})
                2'b10: r_count <= r_count - CW'(1);
                2'b01: begin
                    if (r_count == FULL) begin
                        r_overflow <= 1'b1;
                    end else begin
                        r_count <= r_count + CW'(1);
                    end
                end
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_issue;
        end
    end

    always_ff @(posedge clock) begin
        if (w_issue) begin
            r_data <= w_head.data;
        end
    end

    assign sender.valid = r_valid;
    assign sender.data  = r_data;
    assign credit_count = r_count;
    assign overflow     = r_overflow;

endmodule

// File: tb/tb_credit_sender.sv
// Directed and random checks of credit_sender (CREDITS=4) against a word
// scoreboard and an independent credit model.
module tb_credit_sender;

    localparam int CREDITS = 4;
    localparam int CW      = $clog2(CREDITS + 1);

    logic          clock = 1'b0;
    logic          reset;
    logic [CW-1:0] credit_count;
    logic          overflow;

    stream_if #(.T(logic [31:0])) rx ();
    flow_if   #(.T(logic [31:0])) tx ();
    flow_if   #(.T(logic [31:0])) cr ();

    credit_sender #(.T(logic [31:0]), .CREDITS(CREDITS)) dut (
        .clock        (clock),
        .reset        (reset),
        .receiver     (rx),
        .sender       (tx),
        .credit_in    (cr),
        .credit_count (credit_count),
        .overflow     (overflow)
    );

    always #5 clock = ~clock;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];
    int          model_cnt;
    logic        model_ovf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: record what the edge will do, then compare just after it.
    task automatic tick();
        logic        acc;
        logic        ret;
        logic        rst;
        logic        v;
        logic [31:0] d;
        int          pre;
        acc = rx.valid && rx.ready && reset;
        ret = cr.valid && reset;
        rst = !reset;
        d   = rx.data;
        @(posedge clock);
        #1;
        if (rst) begin
            exp_q.delete();
            model_cnt = CREDITS;
            model_ovf = 1'b0;
            check("valid_in_reset", 32'(tx.valid), 32'd0);
            check("ready_in_reset", 32'(rx.ready), 32'd0);
        end else begin
            if (acc) exp_q.push_back(d);
            v   = (tx.valid === 1'b1);
            pre = model_cnt;
            if (v) begin
                check("issue_with_credit", 32'(pre != 0), 32'd1);
                check("queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("word_order", tx.data, exp_q.pop_front());
            end
            if (ret && !v && pre == CREDITS) begin
                model_ovf = 1'b1;
            end else begin
                model_cnt = pre - int'(v) + int'(ret);
                if (model_cnt < 0) model_cnt = 0;
            end
        end
        check("credit_count", 32'(credit_count), 32'(model_cnt));
        check("overflow", 32'(overflow), 32'(model_ovf));
    endtask

    task automatic send_words(input logic [31:0] base, input int n);
        int   sent;
        int   budget;
        logic took;
        sent     = 0;
        budget   = 0;
        rx.valid = 1'b1;
        rx.data  = base;
        while (sent < n && budget < 200) begin
            took = rx.ready;
            tick();
            if (took) begin
                sent++;
                rx.data = base + 32'(sent);
            end
            budget++;
        end
        rx.valid = 1'b0;
        check("send_words_done", 32'(sent), 32'(n));
    endtask

    initial begin
        int budget;
        reset     = 1'b0;
        rx.valid  = 1'b0;
        rx.data   = '0;
        cr.valid  = 1'b0;
        cr.data   = '0;
        model_cnt = CREDITS;
        model_ovf = 1'b0;

        // Reset and release
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("ready_after_reset", 32'(rx.ready), 32'd1);

        // Six back-to-back words, four credits
        rx.valid = 1'b1;
        for (int j = 0; j < 6; j++) begin
            rx.data = 32'h10 + 32'(j);
            check("t1_ready_before_accept", 32'(rx.ready), 32'd1);
            tick();
            check("t1_valid_timing", 32'(tx.valid), 32'(j >= 1 && j <= 4));
        end
        rx.valid = 1'b0;
        check("t1_ready_dropped", 32'(rx.ready), 32'd0);
        check("t1_count_zero", 32'(credit_count), 32'd0);

        // Single credit return releases exactly one word
        cr.valid = 1'b1;
        tick();
        cr.valid = 1'b0;
        check("t2_count_one", 32'(credit_count), 32'd1);
        check("t2_no_issue_same_cycle", 32'(tx.valid), 32'd0);
        tick();
        check("t2_issue_next", 32'(tx.valid), 32'd1);
        check("t2_data", tx.data, 32'h14);
        check("t2_count_back_zero", 32'(credit_count), 32'd0);

        // Bring credits to 2 (0x15 drains on the way)
        cr.valid = 1'b1;
        repeat (3) tick();
        cr.valid = 1'b0;
        check("t3_count_two", 32'(credit_count), 32'd2);

        // Issue and return every cycle: count stays at 2
        for (int k = 0; k <= 8; k++) begin
            rx.valid = (k < 8);
            rx.data  = 32'h100 + 32'(k);
            cr.valid = (k >= 1);
            tick();
            if (k >= 1) begin
                check("t3_count_steady", 32'(credit_count), 32'd2);
                check("t3_one_per_cycle", 32'(tx.valid), 32'd1);
            end
        end
        rx.valid = 1'b0;
        cr.valid = 1'b0;

        // Fill credits to CREDITS, then one more sets overflow
        cr.valid = 1'b1;
        tick();
        tick();
        check("t4_count_full", 32'(credit_count), 32'(CREDITS));
        check("t4_no_overflow_yet", 32'(overflow), 32'd0);
        tick();
        cr.valid = 1'b0;
        check("t4_count_saturated", 32'(credit_count), 32'(CREDITS));
        for (int i = 0; i < 100; i++) begin
            tick();
            check("t4_overflow_sticky", 32'(overflow), 32'd1);
        end

        // Reset with two words buffered and one credit
        send_words(32'h200, 6);
        cr.valid = 1'b1;
        tick();
        cr.valid = 1'b0;
        check("t5_count_one", 32'(credit_count), 32'd1);
        reset = 1'b0;
        tick();
        check("t5_valid_cleared", 32'(tx.valid), 32'd0);
        check("t5_count_restored", 32'(credit_count), 32'(CREDITS));
        check("t5_overflow_cleared", 32'(overflow), 32'd0);
        reset = 1'b1;
        repeat (10) tick();
        check("t5_ready_back", 32'(rx.ready), 32'd1);

        // Random traffic and returns, then drain
        for (int i = 0; i < 400; i++) begin
            rx.valid = 1'($urandom_range(0, 1));
            rx.data  = $urandom;
            cr.valid = (model_cnt < CREDITS) ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
        end
        rx.valid = 1'b0;
        budget   = 0;
        while ((exp_q.size() != 0 || model_cnt != CREDITS) && budget < 300) begin
            cr.valid = (model_cnt < CREDITS) ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            budget++;
        end
        cr.valid = 1'b0;
        tick();
        check("t6_all_words_out", 32'(exp_q.size()), 32'd0);
        check("t6_credits_home", 32'(credit_count), 32'(CREDITS));
        check("t6_no_overflow", 32'(overflow), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
